// File: rtl/dbus_bridge_pkg.sv
// Shared types and lane-formatting helpers for the data-bus bridge.
package dbus_bridge_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    // Access size codes taken from funct3[1:0]
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        DbusIdle   = 2'd0,
        DbusStReq  = 2'd1,
        DbusLdReq  = 2'd2,
        DbusLdResp = 2'd3
    } dbus_state_e;

    // One store-queue entry: word-aligned address, byte enables, lane-positioned data
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] data;
    } sq_entry_t;

    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
        return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    endfunction

    function automatic logic [BE_W-1:0] store_be(input logic [1:0] off, input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [XLEN-1:0] wdata,
                                                   input logic [1:0] size);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Right-align the addressed lane; extension is left to the core
    function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0] off,
                                                   input logic [1:0] size);
        case (size)
            SZ_B:    return rdata >> {off, 3'b000};
            SZ_H:    return rdata >> {off[1], 4'b0000};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// Single-outstanding req/ack data bus between the bridge (master) and memory (slave).
interface dbus_bridge_if
    import dbus_bridge_pkg::*;
();
    logic            o_busReq;
    logic            o_busWe;
    logic [XLEN-1:0] o_busAddr;
    logic [XLEN-1:0] o_busWdata;
    logic [BE_W-1:0] o_busBe;
    logic            i_busAck;
    logic [XLEN-1:0] i_busRdata;

    modport master (
        output o_busReq, o_busWe, o_busAddr, o_busWdata, o_busBe,
        input  i_busAck, i_busRdata
    );

    modport slave (
        input  o_busReq, o_busWe, o_busAddr, o_busWdata, o_busBe,
        output i_busAck, i_busRdata
    );
endinterface

// File: rtl/dbus_bridge_store_queue.sv
// Power-of-two FIFO holding pending stores; head is visible without a read strobe.
module dbus_bridge_store_queue #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 68
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enq_i,
    input  logic [Width-1:0] enq_data_i,
    input  logic             deq_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             last_o,
    output logic [Width-1:0] head_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_enq, do_deq;

    // A dequeue in the same cycle frees the slot a full-queue enqueue needs
    always_comb begin
        full_o  = (cnt_q == CntW'(Depth));
        empty_o = (cnt_q == '0);
        last_o  = (cnt_q == CntW'(1));
        do_deq  = deq_i && !empty_o;
        do_enq  = enq_i && (!full_o || do_deq);
        head_o  = mem_q[rd_ptr_q];
    end

    // Pointer and occupancy update; pointers wrap naturally at Depth
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_enq && !do_deq)      cnt_q <= cnt_q + CntW'(1);
            else if (!do_enq && do_deq) cnt_q <= cnt_q - CntW'(1);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_enq) mem_q[wr_ptr_q] <= enq_data_i;
    end

endmodule

// File: rtl/dbus_bridge.sv
// MEM-stage to req/ack bus bridge: queued stores, loads wait for the queue to drain.
module dbus_bridge
    import dbus_bridge_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned SQ_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_loadReq,
    input  logic             i_storeReq,
    input  logic [XLEN-1:0]  i_addr,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [2:0]       i_funct3,
    output logic             o_memValid,
    output logic [XLEN-1:0]  o_rdata,
    dbus_bridge_if.master    bus,
    output logic             o_sqOverflow,
    output logic             o_misaligned
);
    dbus_state_e     state_q, state_d;
    logic [XLEN-1:0] ld_addr_q, ld_addr_d;
    logic [1:0]      ld_size_q, ld_size_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            ovf_q, ovf_d, mis_q, mis_d;

    logic            sq_enq, sq_deq, sq_full, sq_empty, sq_last;
    sq_entry_t       sq_in, sq_head;
    logic            st_mis, ld_start, unused_funct3;

    assign unused_funct3 = i_funct3[2];

    // Store admission and lane formatting of the incoming store
    always_comb begin
        st_mis   = is_misaligned(i_addr[1:0], i_funct3[1:0]);
        sq_in    = '{addr: {i_addr[XLEN-1:2], 2'b00},
                     be:   store_be(i_addr[1:0], i_funct3[1:0]),
                     data: store_data(i_wdata, i_funct3[1:0])};
        sq_deq   = (state_q == DbusStReq) && bus.i_busAck;
        sq_enq   = i_storeReq && !st_mis && (!sq_full || sq_deq);
        ld_start = (state_q == DbusIdle) && sq_empty && i_loadReq;
    end

    dbus_bridge_store_queue #(
        .Depth (SQ_DEPTH),
        .Width ($bits(sq_entry_t))
    ) u_sq (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .enq_i      (sq_enq),
        .enq_data_i (sq_in),
        .deq_i      (sq_deq),
        .full_o     (sq_full),
        .empty_o    (sq_empty),
        .last_o     (sq_last),
        .head_o     (sq_head)
    );

    // Sticky error flags
    always_comb begin
        ovf_d = ovf_q | (i_storeReq && !st_mis && sq_full && !sq_deq);
        mis_d = mis_q | (i_storeReq && st_mis)
                      | (ld_start && is_misaligned(i_addr[1:0], i_funct3[1:0]));
    end

    // FSM next state and bus/core outputs; stores always win over a waiting load
    always_comb begin
        state_d         = state_q;
        ld_addr_d       = ld_addr_q;
        ld_size_d       = ld_size_q;
        rdata_d         = rdata_q;
        bus.o_busReq    = 1'b0;
        bus.o_busWe     = 1'b0;
        bus.o_busAddr   = '0;
        bus.o_busWdata  = '0;
        bus.o_busBe     = '0;
        o_memValid      = 1'b0;
        unique case (state_q)
            DbusIdle: begin
                if (!sq_empty) begin
                    state_d = DbusStReq;
                end else if (i_loadReq) begin
                    state_d   = DbusLdReq;
                    ld_addr_d = i_addr;
                    ld_size_d = i_funct3[1:0];
                end
            end
            DbusStReq: begin
                bus.o_busReq   = 1'b1;
                bus.o_busWe    = 1'b1;
                bus.o_busAddr  = sq_head.addr;
                bus.o_busWdata = sq_head.data;
                bus.o_busBe    = sq_head.be;
                if (bus.i_busAck) begin
                    // A store enqueued alongside the last dequeue keeps us here
                    state_d = (!sq_last || sq_enq) ? DbusStReq : DbusIdle;
                end
            end
            DbusLdReq: begin
                bus.o_busReq  = 1'b1;
                bus.o_busAddr = {ld_addr_q[XLEN-1:2], 2'b00};
                bus.o_busBe   = 4'b1111;
                if (bus.i_busAck) begin
                    rdata_d = load_align(bus.i_busRdata, ld_addr_q[1:0], ld_size_q);
                    state_d = DbusLdResp;
                end
            end
            DbusLdResp: begin
                o_memValid = 1'b1;
                state_d    = DbusIdle;
            end
            default: state_d = DbusIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= DbusIdle;
            ld_addr_q <= '0;
            ld_size_q <= '0;
            rdata_q   <= '0;
            ovf_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            ld_size_q <= ld_size_d;
            rdata_q   <= rdata_d;
            ovf_q     <= ovf_d;
            mis_q     <= mis_d;
        end
    end

    assign o_rdata      = rdata_q;
    assign o_sqOverflow = ovf_q;
    assign o_misaligned = mis_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: vector table plus hand-written multi-cycle sequences.
module tb_dbus_bridge;
    import dbus_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic        store_req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  f3 = '0;
    logic        mem_valid;
    logic [31:0] rdata;
    logic        sq_ovf;
    logic        mis;

    int n_vec = 0;
    int n_err = 0;

    dbus_bridge_if bus_if ();

    dbus_bridge #(
        .XLEN     (32),
        .SQ_DEPTH (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_loadReq    (load_req),
        .i_storeReq   (store_req),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_funct3     (f3),
        .o_memValid   (mem_valid),
        .o_rdata      (rdata),
        .bus          (bus_if.master),
        .o_sqOverflow (sq_ovf),
        .o_misaligned (mis)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no response expected bus activity", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        store_req = 1'b1;
        addr      = a;
        wdata     = d;
        f3        = f;
        tick();
        store_req = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            if (bus_if.o_busReq) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          cnt, reads, pulses, width, maxw;
        bit          pend, done, ack_now;
        logic [71:0] snap;
        logic [31:0] mem [logic [31:0]];

        vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 3'd0, 32'h203, 32'hAB, 32'h0, 32'h200, 4'h8, 32'hABABABAB, 32'h0};
        vecs[3]  = '{1'b1, 3'd1, 32'h202, 32'h0, 32'h80010000, 32'h200, 4'hF, 32'h0, 32'h00008001};
        vecs[4]  = '{1'b0, 3'd0, 32'h300, 32'h5A, 32'h0, 32'h300, 4'h1, 32'h5A5A5A5A, 32'h0};
        vecs[5]  = '{1'b0, 3'd1, 32'h402, 32'h1234, 32'h0, 32'h400, 4'hC, 32'h12341234, 32'h0};
        vecs[6]  = '{1'b0, 3'd1, 32'h400, 32'hBEEF, 32'h0, 32'h400, 4'h3, 32'hBEEFBEEF, 32'h0};
        vecs[7]  = '{1'b1, 3'd0, 32'h501, 32'h0, 32'h11223344, 32'h500, 4'hF, 32'h0, 32'h00112233};
        vecs[8]  = '{1'b1, 3'd0, 32'h503, 32'h0, 32'h11223344, 32'h500, 4'hF, 32'h0, 32'h00000011};
        vecs[9]  = '{1'b1, 3'd1, 32'h500, 32'h0, 32'h11223344, 32'h500, 4'hF, 32'h0, 32'h11223344};
        vecs[10] = '{1'b1, 3'd2, 32'h504, 32'h0, 32'hCAFEF00D, 32'h504, 4'hF, 32'h0, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 3'd0, 32'h502, 32'hC3, 32'h0, 32'h500, 4'h4, 32'hC3C3C3C3, 32'h0};

        bus_if.i_busAck   = 1'b0;
        bus_if.i_busRdata = '0;

        // Reset state
        tick();
        tick();
        check("rst_busReq", 32'(bus_if.o_busReq), 32'h0);
        check("rst_memValid", 32'(mem_valid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ovf", 32'(sq_ovf), 32'h0);
        check("rst_mis", 32'(mis), 32'h0);
        rst_n = 1'b1;
        tick();

        // Reset while a load request is on the bus
        load_req = 1'b1;
        addr     = 32'h40;
        f3       = 3'd2;
        tick();
        check("midrst_req_before", 32'(bus_if.o_busReq), 32'h1);
        rst_n    = 1'b0;
        load_req = 1'b0;
        tick();
        check("midrst_busReq", 32'(bus_if.o_busReq), 32'h0);
        check("midrst_memValid", 32'(mem_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        check("midrst_queue_empty", 32'(bus_if.o_busReq), 32'h0);

        // Vector table, immediate ack
        for (int v = 0; v < 12; v++) begin
            if (!vecs[v].is_load) begin
                do_store(vecs[v].addr, vecs[v].wdata, vecs[v].f3);
                wait_req(ok);
                if (!ok) timeout("st_req");
                else begin
                    check("st_we", 32'(bus_if.o_busWe), 32'h1);
                    check("st_addr", bus_if.o_busAddr, vecs[v].exp_addr);
                    check("st_be", 32'(bus_if.o_busBe), 32'(vecs[v].exp_be));
                    check("st_wdata", bus_if.o_busWdata, vecs[v].exp_wdata);
                    bus_if.i_busAck = 1'b1;
                    tick();
                    bus_if.i_busAck = 1'b0;
                    check("st_done", 32'(bus_if.o_busReq), 32'h0);
                end
            end else begin
                load_req = 1'b1;
                addr     = vecs[v].addr;
                f3       = vecs[v].f3;
                tick();
                check("ld_lat_req", 32'(bus_if.o_busReq), 32'h1);
                check("ld_we", 32'(bus_if.o_busWe), 32'h0);
                check("ld_addr", bus_if.o_busAddr, vecs[v].exp_addr);
                check("ld_be", 32'(bus_if.o_busBe), 32'(vecs[v].exp_be));
                bus_if.i_busAck   = 1'b1;
                bus_if.i_busRdata = vecs[v].brdata;
                tick();
                bus_if.i_busAck = 1'b0;
                check("ld_valid", 32'(mem_valid), 32'h1);
                check("ld_rdata", rdata, vecs[v].exp_rdata);
                load_req = 1'b0;
                tick();
                check("ld_pulse_end", 32'(mem_valid), 32'h0);
            end
        end
        check("tbl_no_ovf", 32'(sq_ovf), 32'h0);
        check("tbl_no_mis", 32'(mis), 32'h0);

        // Fill the queue under a stalled bus, then overflow it
        for (int k = 0; k < 4; k++) do_store(32'h600 + 32'(4 * k), 32'h1000 + 32'(k), 3'd2);
        for (int k = 0; k < 10; k++) tick();
        check("full_no_ovf", 32'(sq_ovf), 32'h0);
        do_store(32'h610, 32'h1004, 3'd2);
        check("ovf_set", 32'(sq_ovf), 32'h1);
        for (int k = 0; k < 4; k++) begin
            wait_req(ok);
            if (!ok) timeout("ovf_drain");
            else begin
                check("ovf_addr", bus_if.o_busAddr, 32'h600 + 32'(4 * k));
                check("ovf_wdata", bus_if.o_busWdata, 32'h1000 + 32'(k));
                bus_if.i_busAck = 1'b1;
                tick();
                bus_if.i_busAck = 1'b0;
            end
        end
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus_if.o_busReq) cnt++;
            tick();
        end
        check("ovf_dropped", 32'(cnt), 32'h0);
        do_reset();
        check("ovf_cleared", 32'(sq_ovf), 32'h0);

        // Two loads with load request held high across both
        load_req = 1'b1;
        addr     = 32'h700;
        f3       = 3'd2;
        reads = 0; pulses = 0; width = 0; maxw = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            bus_if.i_busAck = 1'b0;
            if (bus_if.o_busReq && !bus_if.o_busWe) begin
                reads++;
                bus_if.i_busAck   = 1'b1;
                bus_if.i_busRdata = 32'h0A0B0C0D;
            end
            if (mem_valid) begin
                pulses++;
                width++;
                if (width > maxw) maxw = width;
                check("ld2_rdata", rdata, 32'h0A0B0C0D);
                if (pulses == 2) load_req = 1'b0;
            end else width = 0;
        end
        bus_if.i_busAck = 1'b0;
        check("ld2_reads", 32'(reads), 32'h2);
        check("ld2_pulses", 32'(pulses), 32'h2);
        check("ld2_width", 32'(maxw), 32'h1);

        // Misaligned halfword store is flagged and never reaches the bus
        do_store(32'h101, 32'h1234, 3'd1);
        check("mis_set", 32'(mis), 32'h1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus_if.o_busReq) cnt++;
            tick();
        end
        check("mis_no_write", 32'(cnt), 32'h0);
        do_reset();

        // Random stalls: request fields hold until ack; load sees all earlier stores
        do_store(32'h800, 32'h11111111, 3'd2);
        do_store(32'h801, 32'h22, 3'd0);
        do_store(32'h802, 32'h3344, 3'd1);
        load_req = 1'b1;
        addr     = 32'h800;
        f3       = 3'd2;
        pend = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (bus_if.o_busReq) begin
                if (pend) begin
                    check("stable_addr", bus_if.o_busAddr, snap[31:0]);
                    check("stable_wdata", bus_if.o_busWdata, snap[63:32]);
                    check("stable_ctl", 32'({bus_if.o_busWe, bus_if.o_busBe}), 32'(snap[68:64]));
                end else begin
                    snap = {3'b0, bus_if.o_busWe, bus_if.o_busBe, bus_if.o_busWdata,
                            bus_if.o_busAddr};
                    pend = 1'b1;
                end
                ack_now = ($urandom_range(0, 3) == 0);
                bus_if.i_busAck   = ack_now;
                bus_if.i_busRdata = mem.exists(bus_if.o_busAddr) ? mem[bus_if.o_busAddr] : '0;
                if (ack_now) begin
                    pend = 1'b0;
                    if (bus_if.o_busWe) begin
                        logic [31:0] w;
                        w = mem.exists(bus_if.o_busAddr) ? mem[bus_if.o_busAddr] : '0;
                        for (int b = 0; b < 4; b++)
                            if (bus_if.o_busBe[b]) w[8*b +: 8] = bus_if.o_busWdata[8*b +: 8];
                        mem[bus_if.o_busAddr] = w;
                    end
                end
            end else begin
                bus_if.i_busAck = 1'b0;
                pend = 1'b0;
            end
            if (mem_valid) begin
                check("order_rdata", rdata, 32'h33442211);
                load_req = 1'b0;
                done = 1'b1;
            end
            tick();
        end
        bus_if.i_busAck = 1'b0;
        if (!done) timeout("stall_load");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
Sits directly downstream of the core's MEM stage. It converts the core's level load request and one-cycle store pulses into a single-outstanding req/ack data bus with byte enables. A store queue absorbs back-to-back stores so the core never stalls on a store. Loads complete only after all queued stores drain, and the bridge returns right-aligned read data with a one-cycle valid pulse that drives the core's memValid input.

Parameters:
XLEN, 32, data/address width (only 32 supported)
SQ_DEPTH, 4, store-queue entries (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_loadReq  in  1  core load request; held high until o_memValid
i_storeReq  in  1  core store pulse; one cycle per store
i_addr  in  XLEN  core data address (byte)
i_wdata  in  XLEN  store data, zero-extended in bits [7:0]/[15:0]/[31:0]
i_funct3  in  3  MEM-stage funct3; size is [1:0] (0=B, 1=H, 2=W)
o_memValid  out  1  one-cycle load-complete pulse
o_rdata  out  XLEN  load data, right-aligned, valid with o_memValid
o_busReq  out  1  bus request
o_busWe  out  1  1 = write
o_busAddr  out  XLEN  word-aligned address ({i_addr[31:2],2'b00})
o_busWdata  out  XLEN  lane-positioned write data
o_busBe  out  4  byte enables
i_busAck  in  1  transfer done; read data valid this cycle
i_busRdata  in  XLEN  bus read data
o_sqOverflow  out  1  sticky: store arrived while queue full
o_misaligned  out  1  sticky: H with addr[0]=1 or W with addr[1:0]!=0

Behaviour:
- Reset (i_rst_n=0 at posedge): state IDLE, queue emptied, all outputs 0, sticky flags cleared.
  - Mid-transaction reset drops o_busReq the next cycle; the bus slave must tolerate an abandoned request.
- Store enqueue: i_storeReq=1 enqueues {addr, be, data} in the same cycle the core presents it.
  - Lane formatting: B: be=4'b0001<<addr[1:0], data=byte replicated x4. H: be=addr[1]?4'b1100:4'b0011, data=halfword replicated x2. W: be=4'b1111.
  - Misaligned store: not enqueued; o_misaligned set.
  - Store while full: dropped; o_sqOverflow set. A simultaneous dequeue in that cycle frees a slot, so that case is not full.
- Queue: FIFO with pointers wrapping mod SQ_DEPTH. Enqueue and dequeue in the same cycle are legal; count is unchanged.
- FSM states: IDLE, ST_REQ, LD_REQ, LD_RESP.
  - IDLE: queue non-empty -> ST_REQ (stores have priority). Else i_loadReq=1 -> LD_REQ, latching addr and funct3. Else stay.
  - ST_REQ: o_busReq=1, o_busWe=1, bus fields from queue head. On i_busAck: dequeue; next state ST_REQ if entries remain, else IDLE.
  - LD_REQ: o_busReq=1, o_busWe=0, o_busBe=4'b1111. On i_busAck: register shifted read data -> LD_RESP.
  - LD_RESP: o_memValid=1 for exactly one cycle -> IDLE. A still-high i_loadReq is ignored in this cycle; i_loadReq seen in IDLE afterward is a new load.
- Bus rules: request fields are stable while o_busReq=1 until ack. i_busAck is ignored when o_busReq=0. Ack may come in the first request cycle.
- Load data: o_rdata = i_busRdata >> (8*addr[1:0]) for B, >> (16*addr[1]) for H, unshifted for W. Sign/zero extension is done by the core.
- Misaligned load: o_misaligned set; the load still completes using the aligned word.
- Latency, empty queue, immediate ack: load seen in cycle 0, o_busReq in cycle 1, o_memValid in cycle 2. Each queued store ahead of the load adds at least 1 cycle.
- Ordering: every load observes all earlier stores.
- o_memValid is never asserted without a prior i_loadReq.

Decomposition:
- types.vh holds:
  - size codes SZ_B/SZ_H/SZ_W;
  - FSM state encoding for DBUS_IDLE, DBUS_ST_REQ, DBUS_LD_REQ, DBUS_LD_RESP;
  - BE width constant.
- Sub-module store_queue: parameterised FIFO with 68-bit entries (addr 32, be 4, data 32), ports enq/deq/full/empty/head.
- Lane formatting and the FSM stay in dbus_bridge.

Test Plan:
- Reset mid-LD_REQ: pull i_rst_n low with o_busReq=1 -> next cycle o_busReq=0, o_memValid=0, queue empty.
- SW 0xDEADBEEF@0x100, then LW 0x100 with ack immediate -> bus write be=1111, then read. o_memValid asserts 1 cycle after the read ack with o_rdata=0xDEADBEEF.
- SB 0xAB@0x203 -> be=1000, wdata=0xABABABAB. LH@0x202 with busRdata=0x8001_0000 -> o_rdata=0x00008001.
- 4 back-to-back SW with i_busAck held low for 10 cycles -> no overflow. A 5th SW -> o_sqOverflow=1 and the entry is dropped. Once acked, exactly 4 writes appear in order.
- Two consecutive loads with i_loadReq held high throughout -> exactly two bus reads and two single-cycle o_memValid pulses.
- SH@0x101 -> o_misaligned=1, no bus write. Random stall/ack pattern -> o_busAddr/o_busWdata/o_busBe stable while o_busReq=1 until i_busAck.
